// File: rtl/hpdcache_refill_victim_ctrl_pkg.sv
// Shared cache geometry defaults, set/way vector types and width helper for the
// refill victim controller slice.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_SETS = 64;
  localparam int unsigned HPDCACHE_WAYS = 4;

  function automatic int unsigned hpdcache_set_width(input int unsigned sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  localparam int unsigned HPDCACHE_SET_W = hpdcache_set_width(HPDCACHE_SETS);

  typedef logic [HPDCACHE_SET_W-1:0] hpdcache_set_t;
  typedef logic [HPDCACHE_WAYS-1:0]  hpdcache_way_t;

endpackage

// File: rtl/hpdcache_prio_1hot_encoder.sv
// Keeps the lowest-index set bit of a vector (bit 0 when the vector is empty)
// and flags whether the input was already exactly one-hot.
module hpdcache_prio_1hot_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] onehot_o,
  output logic         is_onehot_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (val_i[i] && !found) begin
        onehot_o[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      onehot_o[0] = 1'b1;
    end
  end

  assign is_onehot_o = (val_i != '0) && ((val_i & (val_i - 1'b1)) == '0);

endmodule

// File: rtl/hpdcache_refill_victim_ctrl.sv
// Refill allocation: directory read, one victim-selector request, optional
// writeback of a dirty victim, then the allocated way goes back to the refill path.
// Define HPDCACHE_REFILL_VICTIM_CHECK_EN to sanitise the victim vector and flag
// non-one-hot selections on err_o.
module hpdcache_refill_victim_ctrl
  import hpdcache_pkg::*;
#(
  parameter  int unsigned SETS  = HPDCACHE_SETS,
  parameter  int unsigned WAYS  = HPDCACHE_WAYS,
  localparam int unsigned SET_W = hpdcache_set_width(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SET_W-1:0] req_set_i,
  output logic             dir_rd_o,
  output logic [SET_W-1:0] dir_rd_set_o,
  input  logic [WAYS-1:0]  dir_valid_i,
  input  logic [WAYS-1:0]  dir_dirty_i,
  output logic             repl_o,
  output logic [SET_W-1:0] repl_set_o,
  output logic [WAYS-1:0]  repl_dir_valid_o,
  output logic             repl_updt_o,
  input  logic [WAYS-1:0]  victim_way_i,
  output logic             evict_valid_o,
  input  logic             evict_ready_i,
  output logic [SET_W-1:0] evict_set_o,
  output logic [WAYS-1:0]  evict_way_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [SET_W-1:0] rsp_set_o,
  output logic [WAYS-1:0]  rsp_way_o,
  output logic             rsp_evicted_o,
  output logic             err_o
);

  typedef enum logic [2:0] {IDLE, DIR_WAIT, SELECT, EVICT, RESP} state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAYS-1:0]  valid_q, valid_d;
  logic [WAYS-1:0]  dirty_q, dirty_d;
  logic [WAYS-1:0]  victim_q, victim_d;
  logic             evicted_q, evicted_d;
  logic             err_q, err_d;

  logic [WAYS-1:0]  victim_sel;
  logic             victim_bad;
  logic [WAYS-1:0]  enc_way;
  logic             enc_ok;

  hpdcache_prio_1hot_encoder #(.N(WAYS)) u_victim_enc (
    .val_i      (victim_way_i),
    .onehot_o   (enc_way),
    .is_onehot_o(enc_ok)
  );

`ifdef HPDCACHE_REFILL_VICTIM_CHECK_EN
  assign victim_sel = enc_way;
  assign victim_bad = ~enc_ok;
`else
  // Selector output is trusted as-is; the encoder result is deliberately unused.
  logic unused_enc;
  assign unused_enc = ^{enc_way, enc_ok};
  assign victim_sel = victim_way_i;
  assign victim_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      set_q     <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      victim_q  <= '0;
      evicted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      victim_q  <= victim_d;
      evicted_q <= evicted_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    set_d            = set_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    victim_d         = victim_q;
    evicted_d        = evicted_q;
    err_d            = err_q;
    req_ready_o      = 1'b0;
    dir_rd_o         = 1'b0;
    dir_rd_set_o     = '0;
    repl_o           = 1'b0;
    repl_set_o       = '0;
    repl_dir_valid_o = '0;
    repl_updt_o      = 1'b0;
    evict_valid_o    = 1'b0;
    evict_set_o      = '0;
    evict_way_o      = '0;
    rsp_valid_o      = 1'b0;
    rsp_set_o        = '0;
    rsp_way_o        = '0;
    rsp_evicted_o    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          set_d        = req_set_i;
          dir_rd_o     = 1'b1;
          dir_rd_set_o = req_set_i;
          state_d      = DIR_WAIT;
        end
      end
      DIR_WAIT: begin
        valid_d = dir_valid_i;
        dirty_d = dir_dirty_i;
        state_d = SELECT;
      end
      SELECT: begin
        repl_o           = 1'b1;
        repl_set_o       = set_q;
        repl_dir_valid_o = valid_q;
        repl_updt_o      = 1'b1;
        victim_d         = victim_sel;
        err_d            = err_q | victim_bad;
        // Only a line that is both present and modified needs a writeback.
        state_d = ((victim_sel & valid_q & dirty_q) != '0) ? EVICT : RESP;
      end
      EVICT: begin
        evict_valid_o = 1'b1;
        evict_set_o   = set_q;
        evict_way_o   = victim_q;
        if (evict_ready_i) begin
          evicted_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_set_o     = set_q;
        rsp_way_o     = victim_q;
        rsp_evicted_o = evicted_q;
        if (rsp_ready_i) begin
          evicted_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_o = err_q;

endmodule
